calc_ctrl_fsm: RTL and testbench
================================

// Module: calc_ctrl_fsm
// PURPOSE
//  Parametrised calculator control FSM. Takes debounced keypad events, builds two DIGITS-nibble
//  operands, drives the ALU with a start/done handshake and selects what the display shows.
//  Adds operator chaining, a two-stage AC, ALU error/timeout handling and a locked ERROR state.
//  Sits between keypad scanner and ALU/display mux in the calculator top level.
// PARAMETERS
//  DIGITS       4   nibbles per operand; W = 4*DIGITS (localparam, not overridable)
//  ALU_TIMEOUT  15  max cycles in WAIT_ALU before ERROR (>=1)
//  CHAIN_EN     1   1: operator pressed in ENTER_B computes, then continues on the result
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  key_valid    in   1   high while a key is held (already synchronised/debounced)
//  key_code     in   4   0-9 digits, 10 EQ, 11 AC, 12 ADD, 13 SUB, 14 MUL, 15 DIV
//  alu_res      in   W   ALU result, valid when alu_done=1
//  alu_done     in   1   one-cycle pulse, result ready
//  alu_err      in   1   qualified by alu_done; div-by-zero/overflow
//  num1, num2   out  W   operands to ALU
//  operation    out  4   latched operator code (12-15)
//  alu_start    out  1   one-cycle start pulse
//  disp_data    out  W   value to display
//  disp_sel     out  2   0 A, 1 B, 2 RESULT, 3 ERROR
//  err_flag     out  1   high in ERROR
//  busy         out  1   high in START/WAIT_ALU
// BEHAVIOUR
//  Reset: all outputs 0, state ENTER_A, digit count 0, key event logic disarmed.
//  Key event: key_code latched on key_valid 0->1; event fires on 1->0 (release); registers and
//   state update on the clock edge after the release is sampled (1-cycle latency). A key held
//   through reset is ignored (arm only on a post-reset rising edge). Events in START/WAIT_ALU dropped.
//  Digit entry: cur = {cur[W-5:0], key}; count saturates at DIGITS, further digits ignored.
//  ENTER_A: digit->num1; op->operation, num2=0, count=0, ENTER_B; EQ ignored;
//   AC: num1=0 (count 0).
//  ENTER_B: digit->num2; EQ with count>0 -> START (EQ with count 0 ignored);
//   op with count>0 & CHAIN_EN -> START, pending op stored; op with count 0 replaces operation;
//   AC with count>0 clears num2; AC with count 0 -> full clear, ENTER_A.
//  START: alu_start=1 for exactly this cycle -> WAIT_ALU, timer=0.
//  WAIT_ALU: alu_done&!alu_err -> SHOW_RES (or, if pending op: num1=alu_res, num2=0,
//   operation=pending, ENTER_B). alu_done&alu_err, or timer==ALU_TIMEOUT -> ERROR.
//   alu_done on the START cycle is ignored.
//  SHOW_RES: digit -> num1={0,key}, num2=0, ENTER_A; op -> num1=alu_res latched, ENTER_B;
//   EQ repeats last op with num1=result (-> START); AC -> full clear.
//  ERROR: disp_data={DIGITS{4'hE}}, err_flag=1; only AC accepted -> full clear, ENTER_A.
//  Display: ENTER_A num1, ENTER_B num2 (num1 until first B digit), SHOW_RES/START/WAIT_ALU last result.
//  Reset mid-operation wins over any event/alu_done in the same cycle.
// STRUCTURE
//  Shared package calc_pkg: key codes, state encoding, disp_sel codes, ERR nibble.
//  Sub-module calc_key_event: edge detect, key latch, arm-after-reset, 1-cycle key_evt pulse.
//  FSM, operand shifters, timeout counter in this module.
// TESTING (DIGITS=4, ALU_TIMEOUT=15)
//  1 keys 1,2,3 -> num1=16'h0123, disp_sel=0, disp_data=16'h0123
//  2 keys 1,2,3,4,5 -> num1=16'h1234 (5th ignored)
//  3 1,2,ADD,3,4,EQ; alu_done+alu_res=16'h0046 3 cycles after start -> one alu_start pulse,
//    num1=0x0012,num2=0x0034,operation=12, disp_data=16'h0046, disp_sel=2
//  4 chain 2,ADD,3,SUB (alu_res=5) -> num1=5,num2=0,operation=13,ENTER_B; then 4,EQ -> start with 5,4
//  5 ADD with no alu_done for 16 cycles -> err_flag=1, disp=16'hEEEE; digit ignored; AC -> all 0
//  6 reset during WAIT_ALU with key held -> next cycle outputs 0, ENTER_A; key release ignored

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, state encoding and display codes for the calculator controller
package calc_pkg;

    localparam logic [3:0] KEY_EQ  = 4'd10;
    localparam logic [3:0] KEY_AC  = 4'd11;
    localparam logic [3:0] KEY_ADD = 4'd12;
    localparam logic [3:0] KEY_SUB = 4'd13;
    localparam logic [3:0] KEY_MUL = 4'd14;
    localparam logic [3:0] KEY_DIV = 4'd15;

    localparam logic [1:0] DISP_A   = 2'd0;
    localparam logic [1:0] DISP_B   = 2'd1;
    localparam logic [1:0] DISP_RES = 2'd2;
    localparam logic [1:0] DISP_ERR = 2'd3;

    localparam logic [3:0] ERR_NIBBLE = 4'hE;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT_ALU = 3'd3,
        ST_SHOW_RES = 3'd4,
        ST_ERROR    = 3'd5
    } calc_state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return (k < KEY_EQ);
    endfunction

    // Operator codes occupy the top of the code space (ADD..DIV).
    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD);
    endfunction

endpackage

// File: rtl/calc_ctrl_fsm_if.sv
// rtl/calc_ctrl_fsm_if.sv - keypad, ALU and display bundle between calculator controller and its neighbours
//  master: keypad/ALU side (drives key_*, alu_res/alu_done/alu_err)
//  slave : controller side (drives num1/num2/operation/alu_start/disp_*/err_flag/busy)
interface calc_ctrl_fsm_if #(
    parameter int DIGITS = 4
);
    localparam int W = 4 * DIGITS;

    logic         key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] alu_res;
    logic         alu_done;
    logic         alu_err;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic [3:0]   operation;
    logic         alu_start;
    logic [W-1:0] disp_data;
    logic [1:0]   disp_sel;
    logic         err_flag;
    logic         busy;

    modport master (
        output key_valid, key_code, alu_res, alu_done, alu_err,
        input  num1, num2, operation, alu_start, disp_data, disp_sel, err_flag, busy
    );

    modport slave (
        input  key_valid, key_code, alu_res, alu_done, alu_err,
        output num1, num2, operation, alu_start, disp_data, disp_sel, err_flag, busy
    );

endinterface

// File: rtl/calc_key_event.sv
// rtl/calc_key_event.sv - key press/release detector producing a one-cycle event on release
//  clk, reset          : clock, synchronous active-high reset
//  key_valid, key_code : debounced key level and code
//  key_evt             : one-cycle pulse after a release of an armed key
//  key_val             : code latched at the press
module calc_key_event (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_evt,
    output logic [3:0] key_val
);

    logic prev;
    logic armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Pretend the key was already held so a key pressed through reset
            // produces no rising edge and therefore never arms.
            prev    <= 1'b1;
            armed   <= 1'b0;
            key_evt <= 1'b0;
            key_val <= 4'd0;
        end else begin
            prev    <= key_valid;
            key_evt <= 1'b0;
            if (key_valid && !prev) begin
                key_val <= key_code;
                armed   <= 1'b1;
            end else if (!key_valid && prev && armed) begin
                key_evt <= 1'b1;
                armed   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_ctrl_fsm.sv
// rtl/calc_ctrl_fsm.sv - calculator control FSM: operand entry, ALU handshake, chaining, error lock
//  clk, reset : clock, synchronous active-high reset
//  bus        : slave side of calc_ctrl_fsm_if (keys and ALU in; operands, ALU start, display out)
module calc_ctrl_fsm
    import calc_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int ALU_TIMEOUT = 15,
    parameter int CHAIN_EN    = 1
) (
    input  logic            clk,
    input  logic            reset,
    calc_ctrl_fsm_if.slave  bus
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    logic       key_evt;
    logic [3:0] key_val;

    calc_key_event u_key_event (
        .clk       (clk),
        .reset     (reset),
        .key_valid (bus.key_valid),
        .key_code  (bus.key_code),
        .key_evt   (key_evt),
        .key_val   (key_val)
    );

    calc_state_t  state_q, state_n;
    logic [W-1:0] num1_q, num1_n;
    logic [W-1:0] num2_q, num2_n;
    logic [3:0]   op_q, op_n;
    logic [3:0]   pend_op_q, pend_op_n;
    logic         pend_q, pend_n;
    logic [CW-1:0] count_q, count_n;
    logic [W-1:0] res_q, res_n;
    logic [TW-1:0] timer_q, timer_n;
    logic         do_clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ENTER_A;
            num1_q    <= '0;
            num2_q    <= '0;
            op_q      <= 4'd0;
            pend_op_q <= 4'd0;
            pend_q    <= 1'b0;
            count_q   <= '0;
            res_q     <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_n;
            num1_q    <= num1_n;
            num2_q    <= num2_n;
            op_q      <= op_n;
            pend_op_q <= pend_op_n;
            pend_q    <= pend_n;
            count_q   <= count_n;
            res_q     <= res_n;
            timer_q   <= timer_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        num1_n    = num1_q;
        num2_n    = num2_q;
        op_n      = op_q;
        pend_op_n = pend_op_q;
        pend_n    = pend_q;
        count_n   = count_q;
        res_n     = res_q;
        timer_n   = timer_q;
        do_clear  = 1'b0;

        unique case (state_q)
            ST_ENTER_A: begin
                if (key_evt) begin
                    if (is_digit(key_val)) begin
                        if (count_q < CW'(DIGITS)) begin
                            num1_n  = {num1_q[W-5:0], key_val};
                            count_n = count_q + CW'(1);
                        end
                    end else if (is_op(key_val)) begin
                        op_n    = key_val;
                        num2_n  = '0;
                        count_n = '0;
                        state_n = ST_ENTER_B;
                    end else if (key_val == KEY_AC) begin
                        num1_n  = '0;
                        count_n = '0;
                    end
                end
            end
            ST_ENTER_B: begin
                if (key_evt) begin
                    if (is_digit(key_val)) begin
                        if (count_q < CW'(DIGITS)) begin
                            num2_n  = {num2_q[W-5:0], key_val};
                            count_n = count_q + CW'(1);
                        end
                    end else if (is_op(key_val)) begin
                        if (count_q == '0) begin
                            op_n = key_val;
                        end else if (CHAIN_EN != 0) begin
                            // Compute now; the new operator is applied once the result is back.
                            pend_op_n = key_val;
                            pend_n    = 1'b1;
                            state_n   = ST_START;
                        end
                    end else if (key_val == KEY_EQ) begin
                        if (count_q != '0) begin
                            pend_n  = 1'b0;
                            state_n = ST_START;
                        end
                    end else begin
                        if (count_q != '0) begin
                            num2_n  = '0;
                            count_n = '0;
                        end else begin
                            do_clear = 1'b1;
                        end
                    end
                end
            end
            ST_START: begin
                timer_n = '0;
                state_n = ST_WAIT_ALU;
            end
            ST_WAIT_ALU: begin
                if (bus.alu_done) begin
                    if (bus.alu_err) begin
                        state_n = ST_ERROR;
                    end else begin
                        res_n = bus.alu_res;
                        if (pend_q) begin
                            num1_n  = bus.alu_res;
                            num2_n  = '0;
                            op_n    = pend_op_q;
                            pend_n  = 1'b0;
                            count_n = '0;
                            state_n = ST_ENTER_B;
                        end else begin
                            state_n = ST_SHOW_RES;
                        end
                    end
                end else if (timer_q == TW'(ALU_TIMEOUT)) begin
                    state_n = ST_ERROR;
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            ST_SHOW_RES: begin
                if (key_evt) begin
                    if (is_digit(key_val)) begin
                        num1_n  = {{(W-4){1'b0}}, key_val};
                        num2_n  = '0;
                        count_n = CW'(1);
                        state_n = ST_ENTER_A;
                    end else if (is_op(key_val)) begin
                        num1_n  = res_q;
                        num2_n  = '0;
                        op_n    = key_val;
                        count_n = '0;
                        state_n = ST_ENTER_B;
                    end else if (key_val == KEY_EQ) begin
                        // Repeat the last operation with the result as the new left operand.
                        num1_n  = res_q;
                        state_n = ST_START;
                    end else begin
                        do_clear = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                if (key_evt && key_val == KEY_AC) begin
                    do_clear = 1'b1;
                end
            end
            default: begin
                state_n = ST_ENTER_A;
            end
        endcase

        if (do_clear) begin
            state_n   = ST_ENTER_A;
            num1_n    = '0;
            num2_n    = '0;
            op_n      = 4'd0;
            pend_op_n = 4'd0;
            pend_n    = 1'b0;
            count_n   = '0;
            res_n     = '0;
            timer_n   = '0;
        end
    end

    always_comb begin
        bus.num1      = num1_q;
        bus.num2      = num2_q;
        bus.operation = op_q;
        bus.alu_start = 1'b0;
        bus.busy      = 1'b0;
        bus.err_flag  = 1'b0;
        bus.disp_sel  = DISP_A;
        bus.disp_data = num1_q;
        unique case (state_q)
            ST_ENTER_A: begin
            end
            ST_ENTER_B: begin
                // Left operand stays on display until the first B digit arrives.
                if (count_q != '0) begin
                    bus.disp_sel  = DISP_B;
                    bus.disp_data = num2_q;
                end
            end
            ST_START: begin
                bus.alu_start = 1'b1;
                bus.busy      = 1'b1;
                bus.disp_sel  = DISP_RES;
                bus.disp_data = res_q;
            end
            ST_WAIT_ALU: begin
                bus.busy      = 1'b1;
                bus.disp_sel  = DISP_RES;
                bus.disp_data = res_q;
            end
            ST_SHOW_RES: begin
                bus.disp_sel  = DISP_RES;
                bus.disp_data = res_q;
            end
            ST_ERROR: begin
                bus.err_flag  = 1'b1;
                bus.disp_sel  = DISP_ERR;
                bus.disp_data = {DIGITS{ERR_NIBBLE}};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// tb/tb_calc_ctrl_fsm.sv - directed table-driven bench for calc_ctrl_fsm
module tb_calc_ctrl_fsm;
    import calc_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   start_cnt;

    calc_ctrl_fsm_if #(.DIGITS(4)) bus ();

    calc_ctrl_fsm #(.DIGITS(4), .ALU_TIMEOUT(15), .CHAIN_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.alu_start === 1'b1) start_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int          n;
        logic [31:0] keys;
        logic [15:0] e_num1;
        logic [15:0] e_num2;
        logic [3:0]  e_op;
        logic [15:0] e_disp;
        logic [1:0]  e_sel;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.alu_done  = 1'b0;
        bus.alu_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        @(posedge clk);
        #1;
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(posedge clk);
        #1 bus.key_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.alu_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_start_seen"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic alu_reply(input int dly, input logic [15:0] res, input logic err);
        repeat (dly) @(posedge clk);
        #1;
        bus.alu_done = 1'b1;
        bus.alu_res  = res;
        bus.alu_err  = err;
        @(posedge clk);
        #1;
        bus.alu_done = 1'b0;
        bus.alu_err  = 1'b0;
    endtask

    task automatic set_vec(input int i, input int n, input logic [31:0] keys, input logic [15:0] n1,
                           input logic [15:0] n2, input logic [3:0] op, input logic [15:0] d, input logic [1:0] s);
        vecs[i].n      = n;
        vecs[i].keys   = keys;
        vecs[i].e_num1 = n1;
        vecs[i].e_num2 = n2;
        vecs[i].e_op   = op;
        vecs[i].e_disp = d;
        vecs[i].e_sel  = s;
    endtask

    initial begin
        int s0;
        total         = 0;
        bad           = 0;
        start_cnt     = 0;
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.alu_res   = 16'd0;
        bus.alu_done  = 1'b0;
        bus.alu_err   = 1'b0;

        // keys listed first-pressed in the top nibble
        set_vec(0,  0, 32'h0000_0000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 2'd0);
        set_vec(1,  3, 32'h1230_0000, 16'h0123, 16'h0000, 4'h0, 16'h0123, 2'd0);
        set_vec(2,  5, 32'h1234_5000, 16'h1234, 16'h0000, 4'h0, 16'h1234, 2'd0);
        set_vec(3,  3, 32'h12B0_0000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 2'd0);
        set_vec(4,  2, 32'h7C00_0000, 16'h0007, 16'h0000, 4'hC, 16'h0007, 2'd0);
        set_vec(5,  3, 32'h7CD0_0000, 16'h0007, 16'h0000, 4'hD, 16'h0007, 2'd0);
        set_vec(6,  4, 32'h7C89_0000, 16'h0007, 16'h0089, 4'hC, 16'h0089, 2'd1);
        set_vec(7,  4, 32'h7C8B_0000, 16'h0007, 16'h0000, 4'hC, 16'h0007, 2'd0);
        set_vec(8,  3, 32'h7CB0_0000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 2'd0);
        set_vec(9,  2, 32'hA500_0000, 16'h0005, 16'h0000, 4'h0, 16'h0005, 2'd0);
        set_vec(10, 3, 32'h7CA0_0000, 16'h0007, 16'h0000, 4'hC, 16'h0007, 2'd0);
        set_vec(11, 7, 32'h7C12_3450, 16'h0007, 16'h1234, 4'hC, 16'h1234, 2'd1);

        for (int v = 0; v < 12; v++) begin
            logic [31:0] kk;
            do_reset();
            kk = vecs[v].keys;
            for (int j = 0; j < vecs[v].n; j++) press(kk[31-4*j -: 4]);
            @(negedge clk);
            chk($sformatf("v%0d_num1", v), {16'd0, bus.num1}, {16'd0, vecs[v].e_num1});
            chk($sformatf("v%0d_num2", v), {16'd0, bus.num2}, {16'd0, vecs[v].e_num2});
            chk($sformatf("v%0d_op", v), {28'd0, bus.operation}, {28'd0, vecs[v].e_op});
            chk($sformatf("v%0d_disp", v), {16'd0, bus.disp_data}, {16'd0, vecs[v].e_disp});
            chk($sformatf("v%0d_sel", v), {30'd0, bus.disp_sel}, {30'd0, vecs[v].e_sel});
            chk($sformatf("v%0d_busy_err", v), {30'd0, bus.busy, bus.err_flag}, 32'd0);
        end

        // 1 2 + 3 4 = ; a stray alu_done during START must be ignored
        do_reset();
        s0 = start_cnt;
        press(4'd1); press(4'd2); press(KEY_ADD); press(4'd3); press(4'd4); press(KEY_EQ);
        wait_start("add");
        chk("add_num1", {16'd0, bus.num1}, 32'h0012);
        chk("add_num2", {16'd0, bus.num2}, 32'h0034);
        chk("add_op", {28'd0, bus.operation}, 32'd12);
        chk("add_busy", {31'd0, bus.busy}, 32'd1);
        bus.alu_done = 1'b1;
        bus.alu_res  = 16'hDEAD;
        @(posedge clk);
        #1 bus.alu_done = 1'b0;
        alu_reply(2, 16'h0046, 1'b0);
        @(negedge clk);
        chk("add_disp", {16'd0, bus.disp_data}, 32'h0046);
        chk("add_sel", {30'd0, bus.disp_sel}, 32'd2);
        chk("add_busy_done", {31'd0, bus.busy}, 32'd0);
        chk("add_start_pulses", start_cnt - s0, 32'd1);

        // chaining: 2 + 3 - (alu=5) 4 =
        do_reset();
        press(4'd2); press(KEY_ADD); press(4'd3); press(KEY_SUB);
        wait_start("chain1");
        chk("chain1_num1", {16'd0, bus.num1}, 32'h0002);
        chk("chain1_num2", {16'd0, bus.num2}, 32'h0003);
        chk("chain1_op", {28'd0, bus.operation}, 32'd12);
        alu_reply(1, 16'h0005, 1'b0);
        @(negedge clk);
        chk("chain_num1", {16'd0, bus.num1}, 32'h0005);
        chk("chain_num2", {16'd0, bus.num2}, 32'h0000);
        chk("chain_op", {28'd0, bus.operation}, 32'd13);
        chk("chain_busy", {31'd0, bus.busy}, 32'd0);
        chk("chain_disp", {16'd0, bus.disp_data}, 32'h0005);
        press(4'd4);
        chk("chain_b_sel", {30'd0, bus.disp_sel}, 32'd1);
        press(KEY_EQ);
        wait_start("chain2");
        chk("chain2_num1", {16'd0, bus.num1}, 32'h0005);
        chk("chain2_num2", {16'd0, bus.num2}, 32'h0004);
        chk("chain2_op", {28'd0, bus.operation}, 32'd13);
        alu_reply(2, 16'h0001, 1'b0);
        @(negedge clk);
        chk("chain2_disp", {16'd0, bus.disp_data}, 32'h0001);

        // timeout: still waiting after 16 WAIT_ALU cycles, ERROR on the next
        do_reset();
        press(4'd1); press(KEY_ADD); press(4'd2); press(KEY_EQ);
        wait_start("tmo");
        repeat (16) @(negedge clk);
        chk("tmo_not_yet_err", {31'd0, bus.err_flag}, 32'd0);
        chk("tmo_not_yet_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("tmo_err", {31'd0, bus.err_flag}, 32'd1);
        chk("tmo_disp", {16'd0, bus.disp_data}, 32'hEEEE);
        chk("tmo_sel", {30'd0, bus.disp_sel}, 32'd3);
        press(4'd5);
        chk("tmo_digit_err", {31'd0, bus.err_flag}, 32'd1);
        chk("tmo_digit_disp", {16'd0, bus.disp_data}, 32'hEEEE);
        press(KEY_AC);
        chk("tmo_ac_err", {31'd0, bus.err_flag}, 32'd0);
        chk("tmo_ac_nums", {bus.num1, bus.num2}, 32'd0);
        chk("tmo_ac_op", {28'd0, bus.operation}, 32'd0);
        chk("tmo_ac_disp", {14'd0, bus.disp_sel, bus.disp_data}, 32'd0);

        // ALU error flag
        do_reset();
        press(4'd9); press(KEY_DIV); press(4'd0); press(KEY_EQ);
        wait_start("aerr");
        alu_reply(1, 16'h0000, 1'b1);
        @(negedge clk);
        chk("aerr_err", {31'd0, bus.err_flag}, 32'd1);

        // reset while WAIT_ALU with a key held: release afterwards must be ignored
        do_reset();
        press(4'd1); press(KEY_ADD); press(4'd2); press(KEY_EQ);
        wait_start("rst");
        @(posedge clk);
        #1;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd5;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_nums", {bus.num1, bus.num2}, 32'd0);
        chk("rst_flags", {27'd0, bus.operation[0], bus.busy, bus.alu_start, bus.err_flag, bus.disp_sel[0]}, 32'd0);
        chk("rst_disp", {14'd0, bus.disp_sel, bus.disp_data}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.key_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_rel_num1", {16'd0, bus.num1}, 32'd0);
        chk("rst_rel_state", {29'd0, bus.busy, bus.disp_sel}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
